// File: rtl/cp0_ex_ctrl_pkg.sv
// Shared constants and types for the CP0 exception sequencer: excodes,
// exception vector, FSM state encodings and the selected-request record.
package cp0_ex_ctrl_pkg;

    // Exception codes understood by CP0
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Exception entry PC with BEV=1
    localparam logic [31:0] EX_VECTOR_DEFAULT = 32'hBFC0_0380;

    // Sequencer states
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FLUSH    = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    // One stage's exception request after selection
    typedef struct packed {
        logic        hit;
        logic [4:0]  excode;
        logic        bd;
        logic [31:0] pc;
        logic [31:0] badvaddr;
    } ex_req_t;

    // A stage only requests an exception when it is valid and carries a real excode
    function automatic logic stage_has_req(input logic valid, input logic [4:0] code);
        return valid && (code != 5'd0);
    endfunction

endpackage

// File: rtl/ex_prio_sel.sv
// Combinational fixed-priority selector over the four pipeline stages.
// Stage 3 (MEM) is the oldest and wins, then EX, ID and finally IF.
module ex_prio_sel
    import cp0_ex_ctrl_pkg::*;
(
    input  logic [3:0]   i_valid,
    input  logic [19:0]  i_excode,
    input  logic [3:0]   i_bd,
    input  logic [127:0] i_pc,
    input  logic [127:0] i_badvaddr,
    output logic         o_hit,
    output logic [4:0]   o_excode,
    output logic         o_bd,
    output logic [31:0]  o_pc,
    output logic [31:0]  o_badvaddr
);

    ex_req_t w_sel;

    // Walk youngest to oldest so the oldest live stage overwrites the others
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < 4; i++) begin
            if (stage_has_req(i_valid[i], i_excode[5*i +: 5])) begin
                w_sel.hit      = 1'b1;
                w_sel.excode   = i_excode[5*i +: 5];
                w_sel.bd       = i_bd[i];
                w_sel.pc       = i_pc[32*i +: 32];
                w_sel.badvaddr = i_badvaddr[32*i +: 32];
            end
        end
    end

    assign o_hit      = w_sel.hit;
    assign o_excode   = w_sel.excode;
    assign o_bd       = w_sel.bd;
    assign o_pc       = w_sel.pc;
    assign o_badvaddr = w_sel.badvaddr;

endmodule

// File: rtl/cp0_ex_ctrl.sv
// Exception sequencer in front of CP0. Picks the oldest exception or ERET,
// issues a one-cycle CP0 update, flushes the pipeline for FLUSH_CYCLES
// cycles and then offers the redirect PC to fetch over valid/ready.
module cp0_ex_ctrl
    import cp0_ex_ctrl_pkg::*;
#(
    parameter logic [31:0] EX_VECTOR    = EX_VECTOR_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req_valid,
    input  logic [19:0]  req_excode,
    input  logic [3:0]   req_bd,
    input  logic [127:0] req_pc,
    input  logic [127:0] req_badvaddr,
    input  logic         mem_eret,
    input  logic [31:0]  cp0_epc,
    output logic [4:0]   cp0_ex_code,
    output logic         cp0_bd,
    output logic [31:0]  cp0_ex_pc,
    output logic [31:0]  cp0_badvaddr,
    output logic         cp0_eret,
    output logic         flush,
    output logic         redirect_valid,
    output logic [31:0]  redirect_pc,
    input  logic         redirect_ready,
    output logic         busy
);

    localparam logic [3:0] LP_CNT_INIT = 4'(FLUSH_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_first;
    logic        r_isEret;
    logic [4:0]  r_excode;
    logic        r_bd;
    logic [31:0] r_pc;
    logic [31:0] r_badvaddr;
    logic [31:0] r_target;

    logic        w_selHit;
    logic [4:0]  w_selExcode;
    logic        w_selBd;
    logic [31:0] w_selPc;
    logic [31:0] w_selBadvaddr;
    logic        w_memHit;
    logic        w_takeExc;
    logic        w_takeEret;

    ex_prio_sel u_prio_sel (
        .i_valid    (req_valid),
        .i_excode   (req_excode),
        .i_bd       (req_bd),
        .i_pc       (req_pc),
        .i_badvaddr (req_badvaddr),
        .o_hit      (w_selHit),
        .o_excode   (w_selExcode),
        .o_bd       (w_selBd),
        .o_pc       (w_selPc),
        .o_badvaddr (w_selBadvaddr)
    );

    // A MEM exception beats ERET; ERET beats younger stages since they are wrong-path
    always_comb begin
        w_memHit   = stage_has_req(req_valid[3], req_excode[19:15]);
        w_takeExc  = w_selHit && (w_memHit || !mem_eret);
        w_takeEret = mem_eret && !w_takeExc;
    end

    // State machine, flush counter and latched event fields
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_first    <= 1'b0;
            r_isEret   <= 1'b0;
            r_excode   <= '0;
            r_bd       <= 1'b0;
            r_pc       <= '0;
            r_badvaddr <= '0;
            r_target   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_takeExc || w_takeEret) begin
                        r_state    <= ST_FLUSH;
                        r_cnt      <= LP_CNT_INIT;
                        r_first    <= 1'b1;
                        r_isEret   <= w_takeEret;
                        r_excode   <= w_takeExc ? w_selExcode   : 5'd0;
                        r_bd       <= w_takeExc ? w_selBd       : 1'b0;
                        r_pc       <= w_takeExc ? w_selPc       : 32'd0;
                        r_badvaddr <= w_takeExc ? w_selBadvaddr : 32'd0;
                        r_target   <= w_takeExc ? EX_VECTOR     : cp0_epc;
                    end
                end
                ST_FLUSH: begin
                    r_first <= 1'b0;
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_REDIRECT;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // CP0 update only in the first flush cycle; redirect offered only in REDIRECT
    always_comb begin
        cp0_ex_code    = 5'd0;
        cp0_bd         = 1'b0;
        cp0_ex_pc      = 32'd0;
        cp0_badvaddr   = 32'd0;
        cp0_eret       = 1'b0;
        flush          = (r_state == ST_FLUSH);
        redirect_valid = (r_state == ST_REDIRECT);
        redirect_pc    = 32'd0;
        busy           = (r_state != ST_IDLE);
        if (r_state == ST_FLUSH && r_first) begin
            if (r_isEret) begin
                cp0_eret = 1'b1;
            end else begin
                cp0_ex_code  = r_excode;
                cp0_bd       = r_bd;
                cp0_ex_pc    = r_pc;
                cp0_badvaddr = r_badvaddr;
            end
        end
        if (r_state == ST_REDIRECT) begin
            redirect_pc = r_target;
        end
    end

endmodule
